// File: rtl/screen_pixel_writer.sv
// Read-modify-write pixel client for the 320x240 1-bpp screen RAM write port.
// Optional whole-screen fill engine: define SCREEN_PIXEL_WRITER_FILL_EN.
module screen_pixel_writer #(
    parameter int H_PIXELS  = 320,
    parameter int V_PIXELS  = 240,
    parameter int WORD_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [8:0]  req_x,
    input  logic [7:0]  req_y,
    input  logic [1:0]  req_op,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    input  logic [15:0] mem_rdata,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    output logic        err,
    output logic        busy
`ifdef SCREEN_PIXEL_WRITER_FILL_EN
    ,
    input  logic        fill_start,
    input  logic        fill_value,
    output logic        fill_done
`endif
);

    localparam int WORDS_PER_ROW = H_PIXELS / WORD_BITS;
    localparam int MAX_ADDRESS   = (H_PIXELS * V_PIXELS / WORD_BITS) - 1;
    localparam int BSEL_W        = $clog2(WORD_BITS);

    localparam logic [8:0]  X_LIM = 9'(H_PIXELS);
    localparam logic [7:0]  Y_LIM = 8'(V_PIXELS);
    localparam logic [15:0] ROW16 = 16'(WORDS_PER_ROW);
    localparam logic [15:0] MAXA  = 16'(MAX_ADDRESS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MOD,
        S_WR
`ifdef SCREEN_PIXEL_WRITER_FILL_EN
        ,
        S_FILL
`endif
    } state_t;

    state_t              state_q;
    logic [15:0]         word_addr_q;
    logic [BSEL_W-1:0]   bit_q;
    logic [1:0]          op_q;
    logic [15:0]         mem_addr_q;
    logic                mem_re_q;
    logic                mem_we_q;
    logic [15:0]         mem_wdata_q;
    logic                err_q;

    logic [15:0]         word_addr_d;
    logic                in_range_d;
    logic [15:0]         mod_word_d;

    always_comb begin
        word_addr_d = 16'(req_y) * ROW16 + 16'(req_x >> BSEL_W);
        in_range_d  = (req_x < X_LIM) && (req_y < Y_LIM);
    end

    // Only the addressed bit changes; bit 0 is the leftmost pixel.
    always_comb begin
        mod_word_d = mem_rdata;
        unique case (op_q)
            2'b00:   mod_word_d[bit_q] = 1'b0;
            2'b01:   mod_word_d[bit_q] = 1'b1;
            2'b10:   mod_word_d[bit_q] = ~mem_rdata[bit_q];
            default: mod_word_d = mem_rdata;
        endcase
    end

`ifdef SCREEN_PIXEL_WRITER_FILL_EN
    logic fill_done_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            word_addr_q <= '0;
            bit_q       <= '0;
            op_q        <= '0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
`ifdef SCREEN_PIXEL_WRITER_FILL_EN
            fill_done_q <= 1'b0;
`endif
        end else begin
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef SCREEN_PIXEL_WRITER_FILL_EN
            fill_done_q <= 1'b0;
`endif
            unique case (state_q)
                S_IDLE: begin
`ifdef SCREEN_PIXEL_WRITER_FILL_EN
                    if (fill_start) begin
                        state_q     <= S_FILL;
                        mem_addr_q  <= '0;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= {WORD_BITS{fill_value}};
                    end else
`endif
                    if (req_valid) begin
                        if (in_range_d) begin
                            state_q     <= S_RD;
                            word_addr_q <= word_addr_d;
                            bit_q       <= req_x[BSEL_W-1:0];
                            op_q        <= req_op;
                            mem_addr_q  <= word_addr_d;
                            mem_re_q    <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    state_q <= S_MOD;
                end
                S_MOD: begin
                    state_q     <= S_WR;
                    mem_addr_q  <= word_addr_q;
                    mem_wdata_q <= mod_word_d;
                    mem_we_q    <= 1'b1;
                end
                S_WR: begin
                    state_q <= S_IDLE;
                end
`ifdef SCREEN_PIXEL_WRITER_FILL_EN
                S_FILL: begin
                    if (mem_addr_q == MAXA) begin
                        state_q     <= S_IDLE;
                        fill_done_q <= 1'b1;
                    end else begin
                        mem_addr_q <= mem_addr_q + 16'd1;
                        mem_we_q   <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;
`ifdef SCREEN_PIXEL_WRITER_FILL_EN
    assign fill_done = fill_done_q;
`endif

endmodule

// File: tb/tb_screen_pixel_writer.sv
// Bench for screen_pixel_writer: vector table, hand sequences, random vs pixel model.
// Define SCREEN_PIXEL_WRITER_FILL_EN to also exercise the fill engine.
module tb_screen_pixel_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [8:0]  req_x;
    logic [7:0]  req_y;
    logic [1:0]  req_op;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic [15:0] mem_rdata = '0;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic        err;
    logic        busy;
`ifdef SCREEN_PIXEL_WRITER_FILL_EN
    logic        fill_start;
    logic        fill_value;
    logic        fill_done;
`endif

    screen_pixel_writer dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_op    (req_op),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .err       (err),
        .busy      (busy)
`ifdef SCREEN_PIXEL_WRITER_FILL_EN
        ,
        .fill_start(fill_start),
        .fill_value(fill_value),
        .fill_done (fill_done)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Synchronous screen RAM: read data valid the cycle after mem_re.
    logic [15:0] ram [0:4799];
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
    end

    typedef struct {
        int a;
        int d;
        int c;
    } wr_t;

    int  cyc = 0;
    int  acc_q[$];
    int  re_q[$];
    int  err_q[$];
    int  fd_q[$];
    wr_t we_q[$];
    int  overlap = 0;
    int  notready = 0;

    always @(posedge clk) begin
        if (!reset) begin
            if (req_valid && req_ready) acc_q.push_back(cyc);
            if (mem_re) re_q.push_back(cyc);
            if (mem_we) we_q.push_back('{a: int'(mem_addr), d: int'(mem_wdata), c: cyc});
            if (err) err_q.push_back(cyc);
            if (mem_re && mem_we) overlap++;
            if (!req_ready) notready++;
`ifdef SCREEN_PIXEL_WRITER_FILL_EN
            if (fill_done) fd_q.push_back(cyc);
`endif
        end
        cyc++;
    end

    task automatic clear_log();
        acc_q.delete();
        re_q.delete();
        err_q.delete();
        we_q.delete();
        fd_q.delete();
        notready = 0;
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input int x, input int y, input int op);
        int n;
        n = 0;
        req_x = 9'(x);
        req_y = 8'(y);
        req_op = 2'(op);
        req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, int'({req_ready, mem_re, mem_we, err, busy}), 5'b10000);
        chk({tag, "_addr"}, int'(mem_addr), 0);
        chk({tag, "_wdata"}, int'(mem_wdata), 0);
    endtask

    typedef struct {
        int          x;
        int          y;
        int          op;
        logic [15:0] init;
        int          ea;
        logic [15:0] ed;
        bit          eerr;
        bit          preset;
    } vec_t;

    vec_t v[10];

    bit scr [0:239][0:319];

    initial begin
        v[0] = '{0,   0,   1, 16'h0000, 0,    16'h0001, 1'b0, 1'b1};
        v[1] = '{17,  1,   1, 16'hFFFD, 21,   16'hFFFF, 1'b0, 1'b1};
        v[2] = '{17,  1,   2, 16'h0000, 21,   16'hFFFD, 1'b0, 1'b0};
        v[3] = '{319, 239, 0, 16'hFFFF, 4799, 16'h7FFF, 1'b0, 1'b1};
        v[4] = '{320, 0,   1, 16'h0000, 0,    16'h0000, 1'b1, 1'b0};
        v[5] = '{0,   240, 1, 16'h0000, 0,    16'h0000, 1'b1, 1'b0};
        v[6] = '{5,   3,   3, 16'h1234, 60,   16'h1234, 1'b0, 1'b1};
        v[7] = '{511, 255, 2, 16'h0000, 0,    16'h0000, 1'b1, 1'b0};
        v[8] = '{16,  0,   2, 16'h0001, 1,    16'h0000, 1'b0, 1'b1};
        v[9] = '{303, 100, 0, 16'hA5A5, 2018, 16'h25A5, 1'b0, 1'b1};

        for (int i = 0; i < 4800; i++) ram[i] = '0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_x = '0;
        req_y = '0;
        req_op = '0;
`ifdef SCREEN_PIXEL_WRITER_FILL_EN
        fill_start = 1'b0;
        fill_value = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk_reset_outputs("in_reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("after_reset");

        for (int i = 0; i < 10; i++) begin
            if (v[i].preset) ram[v[i].ea] = v[i].init;
            clear_log();
            send(v[i].x, v[i].y, v[i].op);
            repeat (5) @(negedge clk);
            chk($sformatf("v%0d_acc", i), acc_q.size(), 1);
            if (v[i].eerr) begin
                chk($sformatf("v%0d_errcnt", i), err_q.size(), 1);
                if (err_q.size() > 0 && acc_q.size() > 0)
                    chk($sformatf("v%0d_errlat", i), err_q[0] - acc_q[0], 1);
                chk($sformatf("v%0d_nomem", i), re_q.size() + we_q.size(), 0);
                chk($sformatf("v%0d_ready", i), notready, 0);
            end else begin
                chk($sformatf("v%0d_noerr", i), err_q.size(), 0);
                chk($sformatf("v%0d_recnt", i), re_q.size(), 1);
                chk($sformatf("v%0d_wecnt", i), we_q.size(), 1);
                if (we_q.size() > 0 && acc_q.size() > 0) begin
                    chk($sformatf("v%0d_addr", i), we_q[0].a, v[i].ea);
                    chk($sformatf("v%0d_data", i), we_q[0].d, int'(v[i].ed));
                    chk($sformatf("v%0d_welat", i), we_q[0].c - acc_q[0], 3);
                end
                if (re_q.size() > 0 && acc_q.size() > 0)
                    chk($sformatf("v%0d_relat", i), re_q[0] - acc_q[0], 1);
            end
        end

        // Throughput with req_valid held high.
        clear_log();
        req_x = 9'd1;
        req_y = 8'd2;
        req_op = 2'd1;
        req_valid = 1'b1;
        for (int n = 0; n < 40 && acc_q.size() < 3; n++) @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("tput_acc", acc_q.size(), 3);
        chk("tput_wr", we_q.size(), 3);
        if (acc_q.size() >= 3) begin
            chk("tput_gap1", acc_q[1] - acc_q[0], 4);
            chk("tput_gap2", acc_q[2] - acc_q[1], 4);
        end

        // Reset during MOD of the second request.
        clear_log();
        req_x = 9'd2;
        req_y = 8'd2;
        req_op = 2'd1;
        req_valid = 1'b1;
        for (int n = 0; n < 40 && acc_q.size() < 2; n++) @(negedge clk);
        @(posedge clk);
        #2;
        chk("mod_busy", int'(busy), 1);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk_reset_outputs("rst_mod");
        repeat (4) @(negedge clk);
        chk("rst_mod_wr", we_q.size(), 1);
        chk_reset_outputs("rst_mod_hold");
        reset = 1'b0;
        @(negedge clk);

        // Reset while mem_we is high must drop it immediately.
        clear_log();
        send(3, 2, 1);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("wr_we_high", int'(mem_we), 1);
        reset = 1'b1;
        #1;
        chk("wr_we_async", int'(mem_we), 0);
        chk_reset_outputs("rst_wr");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Randomized requests against a pixel-level screen model.
        for (int a = 0; a < 4800; a++) begin
            logic [15:0] w;
            w = 16'($urandom);
            ram[a] = w;
            for (int i = 0; i < 16; i++)
                scr[a / 20][(a % 20) * 16 + i] = w[i];
        end
        for (int t = 0; t < 150; t++) begin
            int x, y, op;
            logic [15:0] ew;
            x = $urandom_range(0, 335);
            y = $urandom_range(0, 250);
            op = $urandom_range(0, 3);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            clear_log();
            send(x, y, op);
            repeat (4) @(negedge clk);
            if (x >= 320 || y >= 240) begin
                chk($sformatf("r%0d_err", t), err_q.size(), 1);
                chk($sformatf("r%0d_nowr", t), we_q.size(), 0);
            end else begin
                case (op)
                    0: scr[y][x] = 1'b0;
                    1: scr[y][x] = 1'b1;
                    2: scr[y][x] = ~scr[y][x];
                    default: ;
                endcase
                for (int i = 0; i < 16; i++) ew[i] = scr[y][(x / 16) * 16 + i];
                chk($sformatf("r%0d_wecnt", t), we_q.size(), 1);
                if (we_q.size() > 0) begin
                    chk($sformatf("r%0d_addr", t), we_q[0].a, y * 20 + x / 16);
                    chk($sformatf("r%0d_data", t), we_q[0].d, int'(ew));
                end
            end
        end
        begin
            int bad;
            bad = 0;
            for (int a = 0; a < 4800; a++)
                for (int i = 0; i < 16; i++)
                    if (ram[a][i] !== scr[a / 20][(a % 20) * 16 + i]) bad++;
            chk("ram_final", bad, 0);
        end

`ifdef SCREEN_PIXEL_WRITER_FILL_EN
        clear_log();
        fill_start = 1'b1;
        fill_value = 1'b1;
        req_valid = 1'b1;
        req_x = 9'd0;
        req_y = 8'd0;
        req_op = 2'd1;
        @(negedge clk);
        fill_start = 1'b0;
        req_valid = 1'b0;
        for (int n = 0; n < 4810 && fd_q.size() == 0; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("fill_noacc", acc_q.size(), 0);
        chk("fill_norb", re_q.size(), 0);
        chk("fill_wcnt", we_q.size(), 4800);
        chk("fill_done_cnt", fd_q.size(), 1);
        if (we_q.size() == 4800) begin
            int bad;
            bad = 0;
            for (int i = 0; i < 4800; i++)
                if (we_q[i].a != i || we_q[i].d != 'hFFFF || we_q[i].c != we_q[0].c + i)
                    bad++;
            chk("fill_seq", bad, 0);
            if (fd_q.size() > 0) chk("fill_done_lat", fd_q[0] - we_q[4799].c, 1);
        end
        chk("fill_idle", int'(req_ready), 1);
`endif

        chk("re_we_overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
